// File: rtl/rv0_rob.sv
// In-order retire buffer: out-of-order completions by tag, one in-order retire per cycle, control transfer squash at retire.
// Latency: completion at head -> ret_valid_o two cycles later. Backpressure: alloc_ready_o low when full, flushing, or a control transfer is retiring.
module rv0_rob #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 8,
    parameter int EXU_CNT = 2,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     alloc_valid_i,
    output logic                     alloc_ready_o,
    input  logic [4:0]               alloc_rd_i,
    input  logic                     alloc_we_i,
    output logic [TAG_W-1:0]         alloc_tag_o,
    input  logic [EXU_CNT-1:0]       cmpl_valid_i,
    input  logic [EXU_CNT*TAG_W-1:0] cmpl_tag_i,
    input  logic [EXU_CNT*XLEN-1:0]  cmpl_data_i,
    input  logic [EXU_CNT-1:0]       cmpl_ct_i,
    input  logic [EXU_CNT*XLEN-1:0]  cmpl_target_i,
    output logic                     ret_valid_o,
    output logic                     ret_we_o,
    output logic [4:0]               ret_rd_o,
    output logic [XLEN-1:0]          ret_data_o,
    output logic                     ct_trans_o,
    output logic [XLEN-1:0]          ct_target_o,
    output logic [TAG_W:0]           count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam logic [TAG_W:0] PTR_ONE = 1;

    logic [TAG_W:0]     head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0]   vld_q, vld_d, done_q, done_d;
    logic [DEPTH-1:0]   we_q, ct_q;
    logic [4:0]         rd_q   [DEPTH];
    logic [XLEN-1:0]    data_q [DEPTH];
    logic [XLEN-1:0]    tgt_q  [DEPTH];

    logic [TAG_W-1:0]   hidx, tidx, cm_tag;
    logic               head_rdy, ret_fire, squash, alloc_fire, cmpl_en;
    logic [DEPTH-1:0]   cm_hit, cm_ct;
    logic [XLEN-1:0]    cm_data [DEPTH];
    logic [XLEN-1:0]    cm_tgt  [DEPTH];

    logic               ret_valid_q, ret_we_q, ct_trans_q;
    logic [4:0]         ret_rd_q;
    logic [XLEN-1:0]    ret_data_q, ct_target_q;

    assign hidx       = head_q[TAG_W-1:0];
    assign tidx       = tail_q[TAG_W-1:0];
    assign full_o     = (hidx == tidx) && (head_q[TAG_W] != tail_q[TAG_W]);
    assign count_o    = tail_q - head_q;
    assign empty_o    = (count_o == '0);
    assign head_rdy   = vld_q[hidx] && done_q[hidx];
    assign ret_fire   = head_rdy && !flush_i;
    assign squash     = ret_fire && ct_q[hidx];
    assign cmpl_en    = !flush_i && !squash;
    assign alloc_ready_o = !full_o && !flush_i && !(head_rdy && ct_q[hidx]);
    assign alloc_fire = alloc_valid_i && alloc_ready_o;
    assign alloc_tag_o = tidx;

    // Walk channels high to low so the lowest channel index wins a tag collision.
    always_comb begin
        cm_hit = '0;
        cm_ct  = '0;
        cm_tag = '0;
        for (int e = 0; e < DEPTH; e++) begin
            cm_data[e] = '0;
            cm_tgt[e]  = '0;
        end
        for (int c = EXU_CNT - 1; c >= 0; c--) begin
            cm_tag = cmpl_tag_i[c*TAG_W +: TAG_W];
            if (cmpl_valid_i[c] && vld_q[cm_tag]) begin
                cm_hit[cm_tag]  = 1'b1;
                cm_ct[cm_tag]   = cmpl_ct_i[c];
                cm_data[cm_tag] = cmpl_data_i[c*XLEN +: XLEN];
                cm_tgt[cm_tag]  = cmpl_target_i[c*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        vld_d  = vld_q;
        done_d = done_q;
        if (flush_i) begin
            tail_d = head_q;
            vld_d  = '0;
        end else if (squash) begin
            head_d = head_q + PTR_ONE;
            tail_d = head_q + PTR_ONE;
            vld_d  = '0;
        end else begin
            done_d = done_q | cm_hit;
            if (ret_fire) begin
                vld_d[hidx] = 1'b0;
                head_d      = head_q + PTR_ONE;
            end
            if (alloc_fire) begin
                vld_d[tidx]  = 1'b1;
                done_d[tidx] = 1'b0;
                tail_d       = tail_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q      <= '0;
            tail_q      <= '0;
            vld_q       <= '0;
            done_q      <= '0;
            ret_valid_q <= 1'b0;
            ret_we_q    <= 1'b0;
            ret_rd_q    <= '0;
            ret_data_q  <= '0;
            ct_trans_q  <= 1'b0;
            ct_target_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            vld_q       <= vld_d;
            done_q      <= done_d;
            ret_valid_q <= ret_fire;
            ret_we_q    <= ret_fire && we_q[hidx] && (rd_q[hidx] != 5'd0);
            ret_rd_q    <= ret_fire ? rd_q[hidx] : 5'd0;
            ret_data_q  <= ret_fire ? data_q[hidx] : '0;
            ct_trans_q  <= squash;
            ct_target_q <= squash ? tgt_q[hidx] : '0;
        end
    end

    // Payload is qualified by valid/done, so it needs no reset.
    always_ff @(posedge clk_i) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (cmpl_en && cm_hit[e]) begin
                data_q[e] <= cm_data[e];
                ct_q[e]   <= cm_ct[e];
                tgt_q[e]  <= cm_tgt[e];
            end
        end
        if (alloc_fire) begin
            rd_q[tidx] <= alloc_rd_i;
            we_q[tidx] <= alloc_we_i;
        end
    end

    assign ret_valid_o = ret_valid_q;
    assign ret_we_o    = ret_we_q;
    assign ret_rd_o    = ret_rd_q;
    assign ret_data_o  = ret_data_q;
    assign ct_trans_o  = ct_trans_q;
    assign ct_target_o = ct_target_q;

endmodule

// File: tb/tb_rv0_rob.sv
// Bench for rv0_rob: directed scenarios plus random traffic, checked against a queue-based model of the buffer.
module tb_rv0_rob;

    localparam int XLEN = 32;
    localparam int DEPTH = 8;
    localparam int EXU_CNT = 2;
    localparam int TAG_W = 3;

    logic               clk, rst_n, flush, alloc_valid, alloc_ready, alloc_we;
    logic [4:0]         alloc_rd;
    logic [TAG_W-1:0]   alloc_tag;
    logic [1:0]         cmpl_valid, cmpl_ct;
    logic [5:0]         cmpl_tag;
    logic [63:0]        cmpl_data, cmpl_target;
    logic               ret_valid, ret_we, ct_trans, empty, full;
    logic [4:0]         ret_rd;
    logic [31:0]        ret_data, ct_target;
    logic [TAG_W:0]     count;

    rv0_rob #(.XLEN(XLEN), .DEPTH(DEPTH), .EXU_CNT(EXU_CNT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
        .alloc_rd_i(alloc_rd), .alloc_we_i(alloc_we), .alloc_tag_o(alloc_tag),
        .cmpl_valid_i(cmpl_valid), .cmpl_tag_i(cmpl_tag), .cmpl_data_i(cmpl_data),
        .cmpl_ct_i(cmpl_ct), .cmpl_target_i(cmpl_target),
        .ret_valid_o(ret_valid), .ret_we_o(ret_we), .ret_rd_o(ret_rd),
        .ret_data_o(ret_data), .ct_trans_o(ct_trans), .ct_target_o(ct_target),
        .count_o(count), .empty_o(empty), .full_o(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  tag;
        logic [4:0]  rd;
        logic        we;
        logic        done;
        logic [31:0] data;
        logic        ct;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    int          m_head;
    logic        e_rv, e_we, e_ct;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_tgt;
    int          total, bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_ready();
        return (mq.size() < DEPTH) && !flush && !(mq.size() > 0 && mq[0].done && mq[0].ct);
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic rdy, sq;
        logic [2:0] tg;
        ent_t n;
        rdy = m_ready();
        e_rv = 0; e_we = 0; e_rd = 0; e_data = 0; e_ct = 0; e_tgt = 0;
        if (flush) begin
            mq.delete();
        end else begin
            sq = 0;
            if (mq.size() > 0 && mq[0].done) begin
                e_rv = 1; e_rd = mq[0].rd; e_data = mq[0].data;
                e_we = mq[0].we && (mq[0].rd != 0);
                sq = mq[0].ct;
                if (sq) begin e_ct = 1; e_tgt = mq[0].tgt; end
                void'(mq.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
            if (sq) mq.delete();
            else begin
                for (int c = 0; c < 2; c++) begin
                    tg = cmpl_tag[c*3 +: 3];
                    if (cmpl_valid[c] && !(c == 1 && cmpl_valid[0] && cmpl_tag[2:0] == tg)) begin
                        foreach (mq[i]) if (mq[i].tag == tg) begin
                            mq[i].done = 1;
                            mq[i].data = cmpl_data[c*32 +: 32];
                            mq[i].ct   = cmpl_ct[c];
                            mq[i].tgt  = cmpl_target[c*32 +: 32];
                        end
                    end
                end
                if (alloc_valid && rdy) begin
                    n.tag = 3'((m_head + mq.size()) % DEPTH);
                    n.rd = alloc_rd; n.we = alloc_we; n.done = 0;
                    n.data = 0; n.ct = 0; n.tgt = 0;
                    mq.push_back(n);
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        chk("alloc_ready", alloc_ready, m_ready());
        chk("alloc_tag", alloc_tag, (m_head + mq.size()) % DEPTH);
        chk("count", count, mq.size());
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == DEPTH);
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("ret_valid", ret_valid, e_rv);
        chk("ret_we", ret_we, e_we);
        chk("ret_rd", ret_rd, e_rd);
        chk("ret_data", ret_data, e_data);
        chk("ct_trans", ct_trans, e_ct);
        chk("ct_target", ct_target, e_tgt);
    endtask

    task automatic idle();
        flush = 0; alloc_valid = 0; alloc_rd = 0; alloc_we = 0;
        cmpl_valid = 0; cmpl_tag = 0; cmpl_data = 0; cmpl_ct = 0; cmpl_target = 0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic we);
        alloc_valid = 1; alloc_rd = rd; alloc_we = we;
    endtask

    task automatic cmpl(input int ch, input int tag, input logic [31:0] d, input logic ct, input logic [31:0] t);
        cmpl_valid[ch] = 1;
        cmpl_tag[ch*3 +: 3] = 3'(tag);
        cmpl_data[ch*32 +: 32] = d;
        cmpl_ct[ch] = ct;
        cmpl_target[ch*32 +: 32] = t;
    endtask

    initial begin
        int h;
        total = 0; bad = 0; m_head = 0;
        e_rv = 0; e_we = 0; e_ct = 0; e_rd = 0; e_data = 0; e_tgt = 0;
        idle();
        rst_n = 0;
        #1;
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_ret_data", ret_data, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", alloc_ready, 1);
        @(negedge clk); @(negedge clk);
        rst_n = 1;

        // 1: fill to full, ninth request refused
        for (int i = 0; i < 8; i++) begin idle(); alloc(5'(i + 1), 1); tick(); end
        idle(); alloc(5'd9, 1); tick();
        chk("t1_full", full, 1);
        chk("t1_count", count, 8);
        chk("t1_ready", alloc_ready, 0);
        idle(); flush = 1; tick(); idle(); tick();

        // 2: complete in reverse order, retire in order
        for (int i = 0; i < 3; i++) begin idle(); alloc(5'(i + 1), 1); tick(); end
        h = m_head;
        idle(); cmpl(0, (h + 2) % 8, 32'hC, 0, 0); tick();
        idle(); cmpl(0, (h + 1) % 8, 32'hB, 0, 0); tick();
        idle(); cmpl(0, h, 32'hA, 0, 0); tick();
        idle(); tick();
        chk("t2_a", ret_data, 32'hA);
        tick(); chk("t2_b", ret_data, 32'hB);
        tick(); chk("t2_c", ret_data, 32'hC);
        tick();

        // 3: two channels in one cycle
        for (int i = 0; i < 2; i++) begin idle(); alloc(5'd4, 1); tick(); end
        h = m_head;
        idle(); cmpl(0, (h + 1) % 8, 32'h11, 0, 0); cmpl(1, h, 32'h22, 0, 0); tick();
        chk("t3_cnt2", count, 2);
        idle(); tick();
        chk("t3_first", ret_data, 32'h22); chk("t3_cnt1", count, 1);
        tick();
        chk("t3_second", ret_data, 32'h11); chk("t3_cnt0", count, 0);

        // 4: control transfer at retire squashes younger entries
        for (int i = 0; i < 4; i++) begin idle(); alloc(5'd1, 1); tick(); end
        h = m_head;
        idle(); cmpl(0, h, 32'h55, 1, 32'h0010_0040); cmpl(1, (h + 1) % 8, 32'h66, 0, 0); tick();
        idle(); cmpl(0, (h + 2) % 8, 32'h77, 0, 0); cmpl(1, (h + 3) % 8, 32'h88, 0, 0); tick();
        chk("t4_ct", ct_trans, 1);
        chk("t4_tgt", ct_target, 32'h0010_0040);
        chk("t4_empty", empty, 1);
        idle(); tick(); tick();

        // 5: flush with a same-cycle completion of the head
        for (int i = 0; i < 4; i++) begin idle(); alloc(5'd2, 1); tick(); end
        idle(); flush = 1; cmpl(0, m_head, 32'h99, 0, 0); tick();
        chk("t5_rv", ret_valid, 0);
        chk("t5_empty", empty, 1);
        idle(); tick();

        // 6: alloc/complete pairs wrapping tags, then random traffic, then async reset
        for (int i = 0; i < 20; i++) begin
            idle(); alloc(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1))); tick();
            idle(); cmpl(0, (m_head + mq.size() - 1) % 8, $urandom, 0, 0); tick();
        end
        for (int i = 0; i < 300; i++) begin
            idle();
            flush = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 2) != 0) alloc(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            for (int c = 0; c < 2; c++)
                if ($urandom_range(0, 1) == 1)
                    cmpl(c, $urandom_range(0, 7), $urandom, $urandom_range(0, 7) == 0, $urandom);
            tick();
        end
        idle(); alloc(5'd3, 1); cmpl(0, m_head, 32'h1234, 0, 0); tick();
        #2 rst_n = 0;
        #1;
        mq.delete(); m_head = 0;
        chk("r_rv", ret_valid, 0); chk("r_we", ret_we, 0); chk("r_rd", ret_rd, 0);
        chk("r_data", ret_data, 0); chk("r_ct", ct_trans, 0); chk("r_tgt", ct_target, 0);
        chk("r_count", count, 0); chk("r_empty", empty, 1);
        idle();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin idle(); alloc(5'(i + 5), 1); tick(); end
        idle(); cmpl(0, 0, 32'hABCD, 0, 0); tick();
        idle(); tick();
        chk("post_rst_data", ret_data, 32'hABCD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
